// File: rtl/codec_cfg_scheduler.sv
// Codec configuration scheduler: replays the WM8731 power-up table, then serves runtime register writes
// through the I2C write engine, with bounded retry. Optional shadow readback when CFG_SHADOW_EN is defined.
module codec_cfg_scheduler #(
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         MAX_RETRY      = 3,
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_init_done,
  output logic        o_busy,
  output logic        o_err,
  output logic [7:0]  o_err_cnt,
  input  logic        i_req_valid,
  input  logic [6:0]  i_req_addr,
  input  logic [8:0]  i_req_data,
  output logic        o_req_ready,
  output logic        o_eng_start,
  output logic [23:0] o_eng_frame,
  input  logic        i_eng_done,
  input  logic        i_eng_nack
`ifdef CFG_SHADOW_EN
  ,
  input  logic [3:0]  i_rd_addr,
  output logic [8:0]  o_rd_data
`endif
);

  // Request handshake: a runtime write transfers on the cycle where i_req_valid && o_req_ready;
  // o_req_ready depends only on the state, so a held request is taken exactly once.
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0] LAST_IDX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_SERVE, S_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          init_done_q, init_done_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [6:0]    req_addr_q, req_addr_d;
  logic [8:0]    req_data_q, req_data_d;

  logic [6:0]    tbl_addr;
  logic [8:0]    tbl_data;
  logic [6:0]    cmd_addr;
  logic [8:0]    cmd_data;
  logic          ack;
  logic          nack_or_tmo;

  // Table is issued from R9 down to R0, so the register address is derived from the index.
  assign tbl_addr = 7'd9 - {3'b000, idx_q};

  always_comb begin
    tbl_data = 9'h000;
    case (idx_q)
      4'd0:    tbl_data = 9'h001;
      4'd1:    tbl_data = 9'h019;
      4'd2:    tbl_data = 9'h042;
      4'd3:    tbl_data = 9'h000;
      4'd4:    tbl_data = 9'h000;
      4'd5:    tbl_data = 9'h015;
      4'd6:    tbl_data = 9'h079;
      4'd7:    tbl_data = 9'h079;
      4'd8:    tbl_data = 9'h097;
      4'd9:    tbl_data = 9'h097;
      default: tbl_data = 9'h000;
    endcase
  end

  // Once init has completed every frame comes from the latched runtime request.
  assign cmd_addr = init_done_q ? req_addr_q : tbl_addr;
  assign cmd_data = init_done_q ? req_data_q : tbl_data;

  assign ack         = (state_q == S_WAIT) && i_eng_done && !i_eng_nack;
  assign nack_or_tmo = (i_eng_done && i_eng_nack) || (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          idx_d   = 4'd0;
          retry_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        gap_d = '0;
        if (ack) begin
          retry_d = '0;
          state_d = S_GAP;
        end else if (nack_or_tmo) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_GAP;
          end else if (!init_done_q) begin
            err_d   = 1'b1;
            state_d = S_FAIL;
          end else begin
            err_d   = 1'b1;
            retry_d = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          // A nonzero retry count means the last attempt failed and must be re-issued.
          if (retry_q != '0) begin
            state_d = S_ISSUE;
          end else if (init_done_q) begin
            state_d = S_SERVE;
          end else if (idx_q == LAST_IDX) begin
            init_done_d = 1'b1;
            state_d     = S_SERVE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_SERVE: begin
        if (i_req_valid) begin
          req_addr_d = i_req_addr;
          req_data_d = i_req_data;
          state_d    = S_ISSUE;
        end
      end
      S_FAIL: begin
        if (i_start) begin
          err_d   = 1'b0;
          idx_d   = 4'd0;
          retry_d = '0;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      retry_q     <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      req_addr_q  <= 7'd0;
      req_data_q  <= 9'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
    end
  end

  assign o_init_done = init_done_q;
  assign o_err       = err_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_busy      = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_GAP);
  assign o_req_ready = (state_q == S_SERVE);
  assign o_eng_start = (state_q == S_ISSUE);
  assign o_eng_frame = ((state_q == S_ISSUE) || (state_q == S_WAIT))
                       ? {DEV_ADDR, 1'b0, cmd_addr, cmd_data} : 24'h000000;

`ifdef CFG_SHADOW_EN
  logic [8:0] shadow_q [10];
  logic [8:0] shadow_d [10];

  always_comb begin
    shadow_d = shadow_q;
    if (ack && (cmd_addr < 7'd10)) shadow_d[cmd_addr[3:0]] = cmd_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 10; i++) shadow_q[i] <= 9'h000;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign o_rd_data = (i_rd_addr < 4'd10) ? shadow_q[i_rd_addr] : 9'h000;
`endif

endmodule

// File: doc/codec_cfg_scheduler.md
Name: codec_cfg_scheduler

Overview:
Sequences all register writes to the audio codec over the shared I2C write engine. After i_start it issues the 10-entry WM8731 power-up table, then serves runtime register-write requests from one requester (volume, mute, sample-rate changes). Each command is handed to the I2C engine as one 24-bit frame. A NACK or timeout triggers a bounded retry. The block sits between top-level control and the I2C bit engine; it owns the only path to that engine.

Parameters:
DEV_ADDR, 7'h1A, codec 7-bit I2C address; frame byte 0 = {DEV_ADDR,1'b0}
MAX_RETRY, 3, re-issues allowed after the first failed attempt of a frame
GAP_CYCLES, 16, idle cycles enforced between consecutive engine starts (minimum 1)
TIMEOUT_CYCLES, 4096, cycles to wait for i_eng_done before the attempt counts as failed

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  level/pulse; starts or restarts the init sequence
o_init_done  output  1  high once all 10 init writes are ACKed
o_busy  output  1  high while a frame is outstanding or in gap
o_err  output  1  sticky; a frame exhausted its retries
o_err_cnt  output  8  total failed attempts, saturating at 255
i_req_valid  input  1  runtime write request
i_req_addr  input  7  codec register address
i_req_data  input  9  codec register data
o_req_ready  output  1  request accepted on valid&&ready
o_eng_start  output  1  one-cycle pulse; engine latches o_eng_frame
o_eng_frame  output  24  {DEV_ADDR,1'b0,addr[6:0],data[8:0]}, MSB sent first
i_eng_done  input  1  one-cycle pulse; frame finished
i_eng_nack  input  1  qualified by i_eng_done; 1 = any byte NACKed

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state S_IDLE; table index 0; retry counter 0.
- Init table, issue order (addr:data): R9:0x001, R8:0x019, R7:0x042, R6:0x000, R5:0x000, R4:0x015, R3:0x079, R2:0x079, R1:0x097, R0:0x097.
- State S_IDLE: wait for i_start, then go to S_ISSUE with init index 0.
- State S_ISSUE: drive o_eng_frame and pulse o_eng_start for 1 cycle. Clear the timeout counter. Go to S_WAIT.
- State S_WAIT: o_eng_frame is held stable; the timeout counter increments.
  - On i_eng_done with i_eng_nack=0: success. Clear the retry counter and go to S_GAP.
  - On i_eng_done with i_eng_nack=1, or when the counter reaches TIMEOUT_CYCLES-1: failure. o_err_cnt increments (saturating).
  - On failure with retry < MAX_RETRY: increment retry and go to S_GAP, then re-issue the same frame.
  - On failure with retries exhausted during init: set o_err and go to S_FAIL.
  - On failure with retries exhausted on a runtime frame: set o_err, drop the request, clear retry, go to S_GAP, then return to S_SERVE.
- State S_GAP: count GAP_CYCLES, then advance.
  - Init: next index, or after index 9 succeeds set o_init_done=1 and go to S_SERVE.
  - Runtime: return to S_SERVE.
  - Retry: return to S_ISSUE.
- State S_SERVE: o_req_ready=1 (combinational on state only). On i_req_valid, latch addr/data and go to S_ISSUE the next cycle; o_req_ready drops in that same next cycle.
- State S_FAIL: o_init_done=0 and o_err=1 hold. i_start clears o_err, resets the index and retry counter, and re-runs init. o_err_cnt is not cleared.
- o_busy=1 in S_ISSUE, S_WAIT and S_GAP; 0 otherwise.
- Ignored inputs:
  - i_eng_done outside S_WAIT.
  - i_start outside S_IDLE and S_FAIL; it does not interrupt in-flight init.
  - i_req_valid before o_init_done.
- Simultaneous i_eng_done and timeout expiry: i_eng_done wins.
- Reset mid-frame: everything returns to reset values at once. The engine is expected to be reset by the same i_rst_n.
- Runtime addresses are not range-checked; any 7-bit address is sent.

Optional Feature:
Macro CFG_SHADOW_EN.
- Defined:
  - Adds input i_rd_addr[3:0] and output o_rd_data[8:0], with a combinational read of a 10x9 shadow register file.
  - The shadow file resets to 0. An entry is updated only when a frame with addr<10 is ACKed.
  - Reads with addr>=10 return 0.
- Undefined: these ports and the storage are absent; all other behaviour is identical.

Test Plan:
- Reset, i_start pulse, engine ACKs every frame 5 cycles after start -> exactly 10 o_eng_start pulses. First frame 24'h341201, last 24'h340097, consecutive starts at least GAP_CYCLES+5 cycles apart. o_init_done=1 after the 10th gap; o_err=0.
- Engine NACKs the 3rd init frame twice, then ACKs -> frame 24'h340E42 is issued 3 times and the sequence completes; o_err_cnt=2, o_err=0.
- Engine never asserts done on the first frame -> 4 starts spaced TIMEOUT+GAP, then o_err=1, S_FAIL, o_init_done=0, o_err_cnt=4. A new i_start re-runs init and clears o_err.
- After init, request addr=7'h02 data=9'h07F held valid -> one accept cycle with o_req_ready low during busy, frame 24'h34047F. A second back-to-back request is accepted only after its gap.
- Runtime request NACKed 4 times -> request dropped, o_err=1, o_init_done stays 1, o_req_ready returns to 1.
- With CFG_SHADOW_EN: after init, i_rd_addr=4 gives 9'h015. After an ACKed runtime write R4:0x011 it gives 9'h011. After a failed write R4:0x000 it still gives 9'h011.
